booth_mul_arbiter: RTL and testbench

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

---
 rtl/booth_arb_pkg.sv | 14 +
 rtl/booth_arb_rr.sv | 19 +
 rtl/booth_multiplier.sv | 69 ++++++
 rtl/booth_mul_arbiter.sv | 134 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_arb_pkg.sv
// Shared types and default sizing for the Booth multiplier arbiter.
package booth_arb_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/booth_arb_rr.sv
// Two-way round-robin picker: on contention the requester not served last wins.
module booth_arb_rr (
    input  logic [1:0] req_valid,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; a lone requester always wins, a tie goes away from 'last'.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one recoding step per cycle, WIDTH steps
// per product. 'valid' rises after the last step and stays high until the next
// start, so a consumer can see a stale valid from the previous product.
module booth_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   multiplicand,
    input  logic signed [WIDTH-1:0]   multiplier,
    output logic                      valid,
    output logic signed [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    // Accumulator carries one guard bit so acc - (-2^(W-1)) cannot overflow.
    logic signed [WIDTH:0]   acc;
    logic signed [WIDTH:0]   m;
    logic signed [WIDTH:0]   sum;
    logic        [WIDTH-1:0] q;
    logic                    qm1;
    logic        [CW-1:0]    cnt;
    logic                    busy;

    // Booth recoding of the current multiplier bit pair.
    always_comb begin
        sum = acc;
        case ({q[0], qm1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // Load on start, then add/subtract and arithmetic-shift once per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            m     <= {multiplicand[WIDTH-1], multiplicand};
            q     <= multiplier;
            qm1   <= 1'b0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            valid <= 1'b0;
        end else if (busy) begin
            acc <= {sum[WIDTH], sum[WIDTH:1]};
            q   <= {sum[0], q[WIDTH-1:1]};
            qm1 <= q[0];
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

    assign result = {acc[WIDTH-1:0], q};

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential Booth multiplier between two requesters. Accepts one
// request at a time, starts the multiplier, waits for a fresh done flag (or a
// timeout) and returns the product tagged with the owner's id.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    input  logic signed [WIDTH-1:0]   req_a0,
    input  logic signed [WIDTH-1:0]   req_b0,
    input  logic signed [WIDTH-1:0]   req_a1,
    input  logic signed [WIDTH-1:0]   req_b1,
    output logic [1:0]                req_ready,
    output logic                      rsp_valid,
    output logic                      rsp_id,
    output logic signed [2*WIDTH-1:0] rsp_result,
    output logic                      rsp_err,
    output logic                      mul_str,
    output logic signed [WIDTH-1:0]   mul_multiplicand,
    output logic signed [WIDTH-1:0]   mul_multiplier,
    input  logic                      mul_valid,
    input  logic signed [2*WIDTH-1:0] mul_result
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [1:0]                grant;
    logic                      last;
    logic                      owner;
    logic signed [WIDTH-1:0]   op_a;
    logic signed [WIDTH-1:0]   op_b;
    logic                      armed;
    logic [CNT_W-1:0]          cnt;
    logic                      done_hit;
    logic                      tmo_hit;

    booth_arb_rr u_rr (
        .req_valid (req_valid),
        .last      (last),
        .grant     (grant)
    );

    // A done flag only counts once it has been seen low during this WAIT.
    assign done_hit = armed & mul_valid;
    assign tmo_hit  = (cnt == CNT_LAST);

    assign mul_multiplicand = op_a;
    assign mul_multiplier   = op_b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; completion is tested before timeout so it wins a tie.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_hit || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded control pulses; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        mul_str   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    if (rst_n) req_ready = grant;
            START:   mul_str = 1'b1;
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, WAIT bookkeeping, response registers and round-robin record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            armed      <= 1'b0;
            cnt        <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            last       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner <= grant[1];
                        op_a  <= grant[1] ? req_a1 : req_a0;
                        op_b  <= grant[1] ? req_b1 : req_b0;
                    end
                end
                START: begin
                    armed <= 1'b0;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (!mul_valid) armed <= 1'b1;
                    if (!tmo_hit)   cnt   <= cnt + CNT_W'(1);
                    if (done_hit) begin
                        rsp_id     <= owner;
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_id     <= owner;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end
                end
                DONE: begin
                    last <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench: arbiter in front of the Booth multiplier, with a switch that
// hides the multiplier's done flag to force the timeout path.
module tb_booth_mul_arbiter;

    localparam int W   = 4;
    localparam int TMO = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [1:0]     req_ready;
    logic           rsp_valid;
    logic           rsp_id;
    logic [2*W-1:0] rsp_result;
    logic           rsp_err;
    logic           mul_str;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_valid, mul_valid_real;
    logic [2*W-1:0] mul_result;
    logic           stub;

    int errors = 0;
    int checks = 0;
    int str_cnt = 0;
    int rsp_cnt = 0;
    int n;
    int snap;

    always #5 clk = ~clk;

    assign mul_valid = stub ? 1'b0 : mul_valid_real;

    booth_mul_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_a0           (a0),
        .req_b0           (b0),
        .req_a1           (a1),
        .req_b1           (b1),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_result       (rsp_result),
        .rsp_err          (rsp_err),
        .mul_str          (mul_str),
        .mul_multiplicand (mul_a),
        .mul_multiplier   (mul_b),
        .mul_valid        (mul_valid),
        .mul_result       (mul_result)
    );

    booth_multiplier #(.WIDTH(W)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_str),
        .multiplicand (mul_a),
        .multiplier   (mul_b),
        .valid        (mul_valid_real),
        .result       (mul_result)
    );

    always @(posedge clk) begin
        if (mul_str)   str_cnt <= str_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: present a request, check the grant, let it be taken.
    task automatic issue(input logic [1:0] rv, input logic [1:0] exp_grant, input string tag);
        req_valid = rv;
        #1;
        chk(tag, 32'(req_ready), 32'(exp_grant));
        @(posedge clk);
        #1;
    endtask

    // Counts falling edges until rsp_valid, bounded by limit.
    task automatic wait_rsp(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rsp_valid && cnt < limit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        stub = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("rst_mul_str",    32'(mul_str),    32'd0);
        chk("rst_mul_a",      32'(mul_a),      32'd0);
        chk("rst_mul_b",      32'(mul_b),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester: 4 * 5 = 20, latency = WIDTH + 3 from the accept cycle
        a0 = 4'h4; b0 = 4'h5;
        snap = str_cnt;
        issue(2'b01, 2'b01, "t1_grant");
        req_valid = 2'b00;
        wait_rsp(60, n);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_latency",   32'(n),         32'(W + 3));
        chk("t1_rsp_id",    32'(rsp_id),    32'd0);
        chk("t1_result",    32'(rsp_result), 32'h14);
        chk("t1_err",       32'(rsp_err),   32'd0);
        chk("t1_mul_a_held", 32'(mul_a),    32'h4);
        chk("t1_mul_b_held", 32'(mul_b),    32'h5);
        chk("t1_one_str",   32'(str_cnt - snap), 32'd1);
        @(negedge clk);
        chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("t1_rsp_hold",  32'(rsp_result), 32'h14);

        // Contention from reset: requester 0 first (-3*5 = F1), then 1 (2*3 = 6)
        do_reset();
        a0 = 4'hD; b0 = 4'h5; a1 = 4'h2; b1 = 4'h3;
        issue(2'b11, 2'b01, "t2_grant0");
        wait_rsp(60, n);
        chk("t2_rsp0_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp0_id",    32'(rsp_id),    32'd0);
        chk("t2_rsp0_res",   32'(rsp_result), 32'hF1);
        @(negedge clk);
        chk("t2_grant1", 32'(req_ready), 32'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp(60, n);
        chk("t2_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp1_id",    32'(rsp_id),    32'd1);
        chk("t2_rsp1_res",   32'(rsp_result), 32'h06);

        // Both held high: grants alternate 0,1,0,1 (3*-2 = FA, -8*-8 = 40)
        a0 = 4'h3; b0 = 4'hE; a1 = 4'h8; b1 = 4'h8;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_grant", 32'(req_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
            @(posedge clk);
            #1;
            wait_rsp(60, n);
            chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t3_rsp_id",    32'(rsp_id),    32'(i % 2));
            chk("t3_rsp_res",   32'(rsp_result), (i % 2 == 0) ? 32'hFA : 32'h40);
        end
        req_valid = 2'b00;

        // Multiplier never completes: error response after TIMEOUT WAIT cycles
        stub = 1'b1;
        @(negedge clk);
        a0 = 4'h5; b0 = 4'h5;
        issue(2'b01, 2'b01, "t4_grant");
        req_valid = 2'b00;
        wait_rsp(100, n);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_cycles",    32'(n),         32'(TMO + 2));
        chk("t4_err",       32'(rsp_err),   32'd1);
        chk("t4_result",    32'(rsp_result), 32'd0);
        chk("t4_id",        32'(rsp_id),    32'd0);
        stub = 1'b0;

        // Normal completion after a timeout clears the error (3*3 = 9)
        @(negedge clk);
        a1 = 4'h3; b1 = 4'h3;
        issue(2'b10, 2'b10, "t5_grant");
        req_valid = 2'b00;
        wait_rsp(60, n);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_id",        32'(rsp_id),    32'd1);
        chk("t5_result",    32'(rsp_result), 32'h09);
        chk("t5_err",       32'(rsp_err),   32'd0);

        // Reset during WAIT: operation dropped silently, outputs cleared
        @(negedge clk);
        a1 = 4'hF; b1 = 4'hF;
        issue(2'b10, 2'b10, "t6_grant");
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mul_str",   32'(mul_str),    32'd0);
        chk("t6_rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("t6_rst_req_ready", 32'(req_ready),  32'd0);
        chk("t6_rst_rsp_id",    32'(rsp_id),     32'd0);
        chk("t6_rst_result",    32'(rsp_result), 32'd0);
        chk("t6_rst_err",       32'(rsp_err),    32'd0);
        chk("t6_rst_mul_a",     32'(mul_a),      32'd0);
        chk("t6_rst_mul_b",     32'(mul_b),      32'd0);
        snap = rsp_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_no_rsp", 32'(rsp_cnt - snap), 32'd0);

        // Next request after the abandoned one: 7 * -8 = C8
        a0 = 4'h7; b0 = 4'h8;
        issue(2'b01, 2'b01, "t7_grant");
        req_valid = 2'b00;
        wait_rsp(60, n);
        chk("t7_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t7_id",        32'(rsp_id),    32'd0);
        chk("t7_result",    32'(rsp_result), 32'hC8);
        chk("t7_err",       32'(rsp_err),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
